// File: rtl/window_pool_binarizer.sv
// Per-channel sliding-window pooling stage. Each channel keeps the last WIN samples and,
// once the window is full, emits one registered result per accepted sample in one of four
// modes: per-tap binarize, window max, binarized max, or raw taps.
module window_pool_binarizer #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int NUM_CH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic [NUM_CH*DATA_W-1:0]       in_data,
  input  logic [1:0]                     mode,
  input  logic [DATA_W-1:0]              thr,
  output logic                           out_valid,
  output logic [NUM_CH*WIN*DATA_W-1:0]   out_data,
  output logic                           win_full
);

  localparam int CW = $clog2(WIN + 1);
  localparam logic [CW-1:0] WIN_CNT  = CW'(WIN);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);

  localparam logic [1:0] MODE_BIN    = 2'd0;
  localparam logic [1:0] MODE_MAX    = 2'd1;
  localparam logic [1:0] MODE_MAXBIN = 2'd2;
  localparam logic [1:0] MODE_RAW    = 2'd3;

  localparam logic [DATA_W-1:0] POS_ONE = DATA_W'(1);
  localparam logic [DATA_W-1:0] NEG_ONE = {DATA_W{1'b1}};

  logic [NUM_CH*WIN*DATA_W-1:0] taps;
  logic [NUM_CH*WIN*DATA_W-1:0] taps_next;
  logic [NUM_CH*WIN*DATA_W-1:0] result;
  logic [CW-1:0]                fill_cnt;
  logic                         fire;
  logic [DATA_W-1:0]            tap_val;
  logic [DATA_W-1:0]            max_val;

  // A sample completes a window when the WIN-1 older taps are already valid.
  assign fire     = in_valid && !clear && (fill_cnt >= WIN_LAST);
  assign win_full = (fill_cnt == WIN_CNT);

  // Shifted window including the sample offered this cycle; also the next tap state.
  always_comb begin
    taps_next = taps;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < WIN; i++) begin
        if (i < WIN - 1) begin
          taps_next[(c*WIN+i)*DATA_W +: DATA_W] = taps[(c*WIN+i+1)*DATA_W +: DATA_W];
        end else begin
          taps_next[(c*WIN+i)*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Mode-dependent window result computed from the post-shift window.
  always_comb begin
    result  = '0;
    tap_val = '0;
    max_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      max_val = taps_next[(c*WIN)*DATA_W +: DATA_W];
      for (int i = 1; i < WIN; i++) begin
        tap_val = taps_next[(c*WIN+i)*DATA_W +: DATA_W];
        if ($signed(tap_val) > $signed(max_val)) max_val = tap_val;
      end
      for (int i = 0; i < WIN; i++) begin
        tap_val = taps_next[(c*WIN+i)*DATA_W +: DATA_W];
        case (mode)
          MODE_BIN: begin
            result[(c*WIN+i)*DATA_W +: DATA_W] =
                ($signed(tap_val) > $signed(thr)) ? POS_ONE : NEG_ONE;
          end
          MODE_MAX: begin
            if (i == 0) result[(c*WIN)*DATA_W +: DATA_W] = max_val;
          end
          MODE_MAXBIN: begin
            if (i == 0) begin
              result[(c*WIN)*DATA_W +: DATA_W] =
                  ($signed(max_val) > $signed(thr)) ? POS_ONE : NEG_ONE;
            end
          end
          MODE_RAW: begin
            result[(c*WIN+i)*DATA_W +: DATA_W] = tap_val;
          end
          default: ;
        endcase
      end
    end
  end

  // Window shift, saturating fill count and registered output; clear beats in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps      <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      taps      <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= fire;
      if (in_valid) begin
        taps <= taps_next;
        if (fill_cnt < WIN_CNT) fill_cnt <= fill_cnt + CW'(1);
      end
      if (fire) out_data <= result;
    end
  end

endmodule

// File: tb/tb_window_pool_binarizer.sv
// Directed self-checking bench for window_pool_binarizer (DATA_W=8, WIN=4, NUM_CH=2).
module tb_window_pool_binarizer;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  mode;
  logic [7:0]  thr;
  logic        out_valid;
  logic [63:0] out_data;
  logic        win_full;

  int checks;
  int errors;

  window_pool_binarizer #(
    .DATA_W (8),
    .WIN    (4),
    .NUM_CH (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mode      (mode),
    .thr       (thr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .win_full  (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One accepted sample per call; returns 1 ns after the capturing edge.
  task automatic push(input logic [7:0] ch0, input logic [7:0] ch1);
    in_data  = {ch1, ch0};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || win_full !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h full=%b required 0/0/0",
               out_valid, out_data, win_full);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bin();
    logic [7:0] seq [4];
    seq[0] = 8'd5; seq[1] = 8'd1; seq[2] = 8'd3; seq[3] = 8'hFC;
    mode = 2'd0;
    thr  = 8'd2;
    for (int k = 0; k < 3; k++) begin
      push(seq[k], seq[k]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bin_early_pulse: sample %0d valid=%b required 0", k, out_valid);
      end
    end
    push(seq[3], seq[3]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFF01FF01_FF01FF01) begin
      errors++;
      $display("FAIL bin_first: valid=%b data=%h required 1/ff01ff01ff01ff01",
               out_valid, out_data);
    end
    checks++;
    if (win_full !== 1'b1) begin
      errors++;
      $display("FAIL bin_win_full: got %b required 1", win_full);
    end
    // Idle cycle with changed mode/thr must not disturb the registered result.
    mode = 2'd3;
    thr  = 8'h80;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'hFF01FF01_FF01FF01) begin
      errors++;
      $display("FAIL bin_hold: valid=%b data=%h required 0/ff01ff01ff01ff01",
               out_valid, out_data);
    end
  endtask

  task automatic test_equality();
    mode = 2'd0;
    thr  = 8'd2;
    push(8'd2, 8'd2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFFFF01FF_FFFF01FF) begin
      errors++;
      $display("FAIL bin_equal: valid=%b data=%h required 1/ffff01ffffff01ff",
               out_valid, out_data);
    end
  endtask

  task automatic test_max();
    do_clear();
    mode = 2'd1;
    push(8'h80, 8'd10);
    push(8'hF9, 8'd127);
    push(8'hFD, 8'd0);
    push(8'hF7, 8'hFF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000007F_000000FD) begin
      errors++;
      $display("FAIL max: valid=%b data=%h required 1/0000007f000000fd", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    mode = 2'd2;
    thr  = 8'hFC;
    push(8'hF8, 8'd0);
    push(8'hFB, 8'd0);
    push(8'hFA, 8'd0);
    push(8'hF9, 8'h80);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000001_000000FF) begin
      errors++;
      $display("FAIL maxbin_below: valid=%b data=%h required 1/00000001000000ff",
               out_valid, out_data);
    end
    push(8'hFD, 8'h80);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000001_00000001) begin
      errors++;
      $display("FAIL maxbin_above: valid=%b data=%h required 1/0000000100000001",
               out_valid, out_data);
    end
  endtask

  task automatic test_most_negative();
    do_clear();
    mode = 2'd0;
    thr  = 8'h80;
    push(8'h80, 8'd127);
    push(8'h80, 8'd127);
    push(8'h80, 8'd127);
    push(8'h81, 8'd127);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h01010101_01FFFFFF) begin
      errors++;
      $display("FAIL bin_min_thr: valid=%b data=%h required 1/0101010101ffffff",
               out_valid, out_data);
    end
  endtask

  task automatic test_clear();
    do_clear();
    checks++;
    if (win_full !== 1'b0 || out_data !== 64'h01010101_01FFFFFF) begin
      errors++;
      $display("FAIL clear_state: full=%b data=%h required 0/0101010101ffffff",
               win_full, out_data);
    end
    mode = 2'd3;
    push(8'd1, 8'd1);
    push(8'd2, 8'd2);
    // Sample offered together with clear must be dropped.
    clear = 1'b1;
    push(8'd3, 8'd3);
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || win_full !== 1'b0) begin
      errors++;
      $display("FAIL clear_dominates: valid=%b full=%b required 0/0", out_valid, win_full);
    end
    push(8'd10, 8'hFF);
    push(8'd20, 8'hFE);
    push(8'd30, 8'hFD);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h01010101_01FFFFFF) begin
      errors++;
      $display("FAIL clear_refill_early: valid=%b data=%h required 0/0101010101ffffff",
               out_valid, out_data);
    end
    push(8'd40, 8'hFC);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hFCFDFEFF_281E140A) begin
      errors++;
      $display("FAIL clear_refill: valid=%b data=%h required 1/fcfdfeff281e140a",
               out_valid, out_data);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'd3;
    push(8'd50, 8'd50);
    push(8'd60, 8'd60);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || win_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h full=%b required 0/0/0",
               out_valid, out_data, win_full);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'd1, 8'd5);
    push(8'h80, 8'd6);
    push(8'd127, 8'd7);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL raw_early: valid=%b required 0", out_valid);
    end
    push(8'd0, 8'd8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h08070605_007F8001) begin
      errors++;
      $display("FAIL raw: valid=%b data=%h required 1/08070605007f8001", out_valid, out_data);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    mode     = 2'd0;
    thr      = '0;
    test_reset();
    test_bin();
    test_equality();
    test_max();
    test_back_to_back();
    test_most_negative();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
